// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the execute stage (req0)
// and the address/auxiliary unit (req1); owns the response register and the flag register.
module alu_share_arbiter #(
    parameter int N = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_req0_valid,
    input  logic [N-1:0] i_req0_src,
    input  logic [N-1:0] i_req0_dst,
    input  logic [1:0]   i_req0_op,
    output logic         o_req0_ready,
    input  logic         i_req1_valid,
    input  logic [N-1:0] i_req1_src,
    input  logic [N-1:0] i_req1_dst,
    input  logic [1:0]   i_req1_op,
    output logic         o_req1_ready,
    output logic [N-1:0] o_alu_src,
    output logic [N-1:0] o_alu_dst,
    output logic [1:0]   o_alu_ctrl,
    input  logic [N-1:0] i_alu_out,
    input  logic         i_alu_carry,
    input  logic         i_alu_zero,
    input  logic         i_alu_neg,
    input  logic         i_resp_ready,
    output logic         o_resp_valid,
    output logic         o_resp_id,
    output logic [N-1:0] o_resp_data,
    output logic         o_resp_err,
    output logic         o_flag_c,
    output logic         o_flag_z,
    output logic         o_flag_n
);

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_NOT  = 2'd1;
    localparam logic [1:0] OP_HOLD = 2'd2;
    localparam logic [1:0] OP_ILL  = 2'd3;

    logic         r_resp_valid;
    logic         r_resp_id;
    logic [N-1:0] r_resp_data;
    logic         r_resp_err;
    logic         r_flag_c;
    logic         r_flag_z;
    logic         r_flag_n;
    logic         r_last_grant;

    logic         w_can_issue;
    logic         w_gnt0;
    logic         w_gnt1;
    logic [1:0]   w_op;
    logic [N-1:0] w_dst;

    // Reset suppresses grants so nothing is consumed from a requester during rst.
    assign w_can_issue = !i_rst && (!r_resp_valid || i_resp_ready);
    assign w_gnt0 = w_can_issue && i_req0_valid && (!i_req1_valid || r_last_grant);
    assign w_gnt1 = w_can_issue && i_req1_valid && (!i_req0_valid || !r_last_grant);

    assign o_req0_ready = w_gnt0;
    assign o_req1_ready = w_gnt1;

    always_comb begin
        o_alu_src = '0;
        w_dst     = '0;
        w_op      = OP_HOLD;
        if (w_gnt0) begin
            o_alu_src = i_req0_src;
            w_dst     = i_req0_dst;
            w_op      = i_req0_op;
        end else if (w_gnt1) begin
            o_alu_src = i_req1_src;
            w_dst     = i_req1_dst;
            w_op      = i_req1_op;
        end
    end

    assign o_alu_dst  = w_dst;
    assign o_alu_ctrl = (w_op == OP_ILL) ? OP_HOLD : w_op;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
            r_flag_c     <= 1'b0;
            r_flag_z     <= 1'b0;
            r_flag_n     <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_gnt0 || w_gnt1) begin
            r_resp_valid <= 1'b1;
            r_resp_id    <= w_gnt1;
            r_last_grant <= w_gnt1;
            r_resp_err   <= (w_op == OP_ILL);
            case (w_op)
                OP_ADD, OP_NOT: begin
                    r_resp_data <= i_alu_out;
                    r_flag_c    <= i_alu_carry;
                    r_flag_z    <= i_alu_zero;
                    r_flag_n    <= i_alu_neg;
                end
                OP_HOLD: r_resp_data <= w_dst;
                default: r_resp_data <= '0;
            endcase
        end else if (i_resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

    assign o_resp_valid = r_resp_valid;
    assign o_resp_id    = r_resp_id;
    assign o_resp_data  = r_resp_data;
    assign o_resp_err   = r_resp_err;
    assign o_flag_c     = r_flag_c;
    assign o_flag_z     = r_flag_z;
    assign o_flag_n     = r_flag_n;

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter and sequencer that shares the single N-bit ALU between two requesters: requester 0 is the execute stage and requester 1 is the address/auxiliary unit. Each cycle the arbiter grants at most one request, drives the ALU operands and control, and registers the result together with the carry, zero and negative flags. The ALU is purely combinational, so this block owns the architectural flag register. It sits between the decode/execute pipeline registers and the ALU.

## Interface
- N, 16, datapath width
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous and active-high; one clock; polarity and synchronicity fixed
- req0_valid / req1_valid  in  1  request present
- req0_src / req1_src  in  N  source operand
- req0_dst / req1_dst  in  N  destination operand
- req0_op / req1_op  in  2  0=ADD, 1=NOT dst, 2=HOLD (no flag update), 3=illegal
- req0_ready / req1_ready  out  1  grant this cycle; combinational
- alu_src, alu_dst  out  N  operands to the ALU; the granted requester's values, else 0
- alu_ctrl  out  2  op to the ALU; the granted op, else 2
- alu_out  in  N  ALU result
- alu_carry, alu_zero, alu_neg  in  1  ALU flags, combinational from the current inputs
- resp_ready  in  1  consumer accepts the response
- resp_valid  out  1  registered result valid
- resp_id  out  1  requester that owns the response
- resp_data  out  N  registered result
- resp_err  out  1  response came from an illegal op
- flag_c, flag_z, flag_n  out  1  architectural flag register

## Operation
- Grant condition: `can_issue = !resp_valid || resp_ready`. Nothing is granted when can_issue=0.
- Arbitration when can_issue=1:
  - Only one requester valid → grant it.
  - Both valid → grant the requester that was not granted last (`last_grant` register).
  - `last_grant` updates only on a grant.
- A transfer happens on a cycle where `reqX_valid && reqX_ready`. The requester holds its operands and op until that cycle.
- Op 0 (ADD):
  - resp_data = alu_out, i.e. (src+dst) mod 2^N.
  - flag_c ← alu_carry, flag_z ← alu_zero, flag_n ← alu_neg. The arbiter captures what the ALU drives.
- Op 1 (NOT): resp_data = alu_out = ~dst. Flags are updated the same way as ADD.
- Op 2 (HOLD): resp_data = dst, and flags are unchanged. The arbiter ignores the ALU outputs for this op.
- Op 3 (illegal):
  - alu_ctrl is driven as 2.
  - resp_data = 0, resp_err = 1, flags unchanged.
- Response register on a grant: resp_valid ← 1, and resp_id, resp_data, resp_err are loaded.
- Response register with no grant: if resp_ready, resp_valid ← 0; otherwise hold all fields.
- Internal state consists only of the response register, the flag register and `last_grant`. No FSM beyond this.

## Timing
- Reset values:
  - resp_valid=0, resp_id=0, resp_data=0, resp_err=0
  - flag_c=flag_z=flag_n=0
  - last_grant=1, so requester 0 wins the first tie
- req*_ready and alu_* outputs are combinational and valid in the same cycle as the request.
- Latency: the result appears on resp_* one cycle after the grant edge. Flags update on the same edge.
- Throughput: one op per cycle when resp_ready=1 continuously.
- Back-pressure: while resp_valid=1 and resp_ready=0, both readys are 0 and the response holds stable.
- Same-cycle response drain plus new grant (resp_valid=1, resp_ready=1, request valid) is allowed. This gives back-to-back responses.
- rst mid-operation:
  - The pending response is dropped and flags are cleared.
  - rst overrides any grant in the same cycle; readys are forced to 0 while rst=1.
- Flags reflect the last non-HOLD, non-illegal op in grant order, regardless of whether its response has been consumed yet.

## Test plan
- Reset, then req0 ADD src=0xFFFF dst=0x0001 with resp_ready=1:
  - next cycle resp_data=0x0000, resp_id=0
  - flag_c=1, flag_z=1, flag_n=0
- Both valid every cycle with resp_ready=1:
  - grants go 0,1,0,1…
  - resp_id alternates starting at 0
- req1 NOT dst=0x00FF → resp_data=0xFF00, flag_n=1, flag_z=0, flag_c=0. Follow with HOLD dst=0x1234 → resp_data=0x1234, and flags still show n=1.
- Op 3 from req0 → resp_err=1, resp_data=0, flags unchanged.
- resp_ready=0 for 3 cycles with req0 valid:
  - readys stay 0 and resp_* is stable
  - on resp_ready=1 a new grant happens in the same cycle, and the next response arrives on the next edge
- Assert rst while resp_valid=1 and both requests are valid:
  - next cycle resp_valid=0, flags are 0, and readys are 0 during rst
  - after release, requester 0 wins the tie
